// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: instruction fields,
// opcodes, FSM state codes, the strobe bundle and opcode classification.
package cpu_pkg;

    localparam int OPW     = 5;   // opcode width
    localparam int STW     = 5;   // state register width
    localparam int IR_W    = 32;  // instruction register width
    localparam int OPC_MSB = 31;  // opcode field position inside ir
    localparam int OPC_LSB = 27;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_AND  = 5'b01001;
    localparam logic [OPW-1:0] OP_OR   = 5'b01010;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPW-1:0] OP_IN   = 5'b10101;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    typedef enum logic [STW-1:0] {
        S_RESET = 5'd0,
        S_T0    = 5'd1,
        S_T1    = 5'd2,
        S_T2    = 5'd3,
        S_T3    = 5'd4,
        S_T4    = 5'd5,
        S_T5    = 5'd6,
        S_T6    = 5'd7,
        S_T7    = 5'd8,
        S_HALT  = 5'd9
    } state_t;

    // Instructions that share an identical T-step sequence.
    typedef enum logic [3:0] {
        CL_LD, CL_LDI, CL_ST, CL_ALU_R, CL_ALU_I, CL_UNARY, CL_MULDIV, CL_BR,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } op_class_t;

    // Every datapath strobe driven by the control unit.
    typedef struct packed {
        logic pc_out;
        logic zlo_out;
        logic zhi_out;
        logic hi_out;
        logic lo_out;
        logic mdr_out;
        logic inport_out;
        logic c_sign_extended_out;
        logic ba_out;
        logic pc_enable;
        logic pc_increment;
        logic mar_enable;
        logic mdr_enable;
        logic ir_enable;
        logic y_enable;
        logic z_enable;
        logic lo_enable;
        logic hi_enable;
        logic r_in;
        logic r_out;
        logic gra;
        logic grb;
        logic grc;
        logic r15_select;
        logic read;
        logic ram_write;
        logic con_enable;
        logic outport_enable;
    } strobes_t;

    // Map an opcode to its sequencing class; undefined opcodes behave as nop.
    function automatic op_class_t classify(input logic [OPW-1:0] opc);
        case (opc)
            OP_LD:                                  return CL_LD;
            OP_LDI:                                 return CL_LDI;
            OP_ST:                                  return CL_ST;
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:          return CL_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:               return CL_ALU_I;
            OP_NEG, OP_NOT:                         return CL_UNARY;
            OP_MUL, OP_DIV:                         return CL_MULDIV;
            OP_BR:                                  return CL_BR;
            OP_JR:                                  return CL_JR;
            OP_JAL:                                 return CL_JAL;
            OP_IN:                                  return CL_IN;
            OP_OUT:                                 return CL_OUT;
            OP_MFHI:                                return CL_MFHI;
            OP_MFLO:                                return CL_MFLO;
            OP_HALT:                                return CL_HALT;
            default:                                return CL_NOP;
        endcase
    endfunction

    // Final T-step of each instruction class.
    function automatic state_t last_step(input op_class_t cls);
        case (cls)
            CL_LD, CL_ST:                           return S_T7;
            CL_LDI, CL_ALU_R, CL_ALU_I:             return S_T5;
            CL_MULDIV, CL_BR:                       return S_T6;
            CL_UNARY, CL_JAL:                       return S_T4;
            CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: return S_T3;
            default:                                return S_T2;
        endcase
    endfunction

    // Advance one T-step.
    function automatic state_t step_after(input state_t s);
        return state_t'(s + {{(STW-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/cu_strobe_decode.sv
// Combinational decode of FSM state plus current opcode into the datapath
// strobe bundle, ALU operation select and run flag.
import cpu_pkg::*;

module cu_strobe_decode (
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic           con_ff,
    output strobes_t       strb,
    output logic [OPW-1:0] alu_op,
    output logic           run
);

    op_class_t cls;

    assign cls = classify(opcode);
    assign run = (state >= S_T0) && (state <= S_T7);

    // Strobes per T-step; alu_op follows the opcode only on the step that loads Z with the result.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
        strb   = '0;
        alu_op = OP_ADD;
        case (state)
            S_RESET, S_HALT: alu_op = '0;
            S_T0: begin
                strb.pc_out       = 1'b1;
                strb.mar_enable   = 1'b1;
                strb.pc_increment = 1'b1;
                strb.z_enable     = 1'b1;
            end
            S_T1: begin
                strb.zlo_out    = 1'b1;
                strb.pc_enable  = 1'b1;
                strb.read       = 1'b1;
                strb.mdr_enable = 1'b1;
            end
            S_T2: begin
                strb.mdr_out   = 1'b1;
                strb.ir_enable = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CL_LD, CL_LDI, CL_ST: begin
                        strb.grb = 1'b1; strb.ba_out = 1'b1; strb.y_enable = 1'b1;
                    end
                    CL_ALU_R, CL_ALU_I: begin
                        strb.grb = 1'b1; strb.r_out = 1'b1; strb.y_enable = 1'b1;
                    end
                    CL_UNARY: begin
                        strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_enable = 1'b1;
                        alu_op = opcode;
                    end
                    CL_MULDIV: begin
                        strb.gra = 1'b1; strb.r_out = 1'b1; strb.y_enable = 1'b1;
                    end
                    CL_BR: begin
                        strb.gra = 1'b1; strb.r_out = 1'b1; strb.con_enable = 1'b1;
                    end
                    CL_JR: begin
                        strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_enable = 1'b1;
                    end
                    CL_JAL: begin
                        strb.pc_out = 1'b1; strb.r15_select = 1'b1; strb.r_in = 1'b1;
                    end
                    CL_IN: begin
                        strb.inport_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
                    end
                    CL_OUT: begin
                        strb.gra = 1'b1; strb.r_out = 1'b1; strb.outport_enable = 1'b1;
                    end
                    CL_MFHI: begin
                        strb.hi_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
                    end
                    CL_MFLO: begin
                        strb.lo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CL_LD, CL_LDI, CL_ST: begin
                        strb.c_sign_extended_out = 1'b1; strb.z_enable = 1'b1;
                    end
                    CL_ALU_R: begin
                        strb.grc = 1'b1; strb.r_out = 1'b1; strb.z_enable = 1'b1;
                        alu_op = opcode;
                    end
                    CL_ALU_I: begin
                        strb.c_sign_extended_out = 1'b1; strb.z_enable = 1'b1;
                        alu_op = opcode;
                    end
                    CL_UNARY: begin
                        strb.zlo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
                    end
                    CL_MULDIV: begin
                        strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_enable = 1'b1;
                        alu_op = opcode;
                    end
                    CL_BR: begin
                        strb.pc_out = 1'b1; strb.y_enable = 1'b1;
                    end
                    CL_JAL: begin
                        strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CL_LDI, CL_ALU_R, CL_ALU_I: begin
                        strb.zlo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        strb.zlo_out = 1'b1; strb.mar_enable = 1'b1;
                    end
                    CL_MULDIV: begin
                        strb.zlo_out = 1'b1; strb.lo_enable = 1'b1;
                    end
                    CL_BR: begin
                        strb.c_sign_extended_out = 1'b1; strb.z_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CL_LD: begin
                        strb.read = 1'b1; strb.mdr_enable = 1'b1;
                    end
                    CL_ST: begin
                        strb.gra = 1'b1; strb.r_out = 1'b1; strb.mdr_enable = 1'b1;
                    end
                    CL_MULDIV: begin
                        strb.zhi_out = 1'b1; strb.hi_enable = 1'b1;
                    end
                    CL_BR: begin
                        // Branch is taken only when the condition flop is set during this step.
                        strb.zlo_out   = 1'b1;
                        strb.pc_enable = con_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CL_LD: begin
                        strb.mdr_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
                    end
                    CL_ST: strb.ram_write = 1'b1;
                    default: ;
                endcase
            end
            default: alu_op = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: state register and next-state sequencing.
// Strobe generation lives in cu_strobe_decode.
import cpu_pkg::*;

module control_unit (
    input  logic             clk,
    input  logic             clr,
    input  logic [IR_W-1:0]  ir,
    input  logic             con_ff,
    input  logic             stop,
    output logic             run,
    output logic [OPW-1:0]   alu_op,
    output logic             pc_out,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             hi_out,
    output logic             lo_out,
    output logic             mdr_out,
    output logic             inport_out,
    output logic             c_sign_extended_out,
    output logic             ba_out,
    output logic             pc_enable,
    output logic             pc_increment,
    output logic             mar_enable,
    output logic             mdr_enable,
    output logic             ir_enable,
    output logic             y_enable,
    output logic             z_enable,
    output logic             lo_enable,
    output logic             hi_enable,
    output logic             r_in,
    output logic             r_out,
    output logic             gra,
    output logic             grb,
    output logic             grc,
    output logic             r15_select,
    output logic             read,
    output logic             ram_write,
    output logic             con_enable,
    output logic             outport_enable
);

    state_t         state;
    state_t         next_state;
    logic [OPW-1:0] opcode;
    op_class_t      cls;
    strobes_t       strb;

    // Register operand fields are consumed by the datapath, not here.
    logic           unused_ir_fields;

    assign opcode           = ir[OPC_MSB:OPC_LSB];
    assign cls              = classify(opcode);
    assign unused_ir_fields = ^ir[OPC_LSB-1:0];

    // State register with synchronous clear; clr aborts any instruction in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so the register samples the pre-edge next_state like every other flop.
        if (clr) state <= S_RESET;
        else     state <= next_state;
    end

    // Next-state sequencing: fetch, then the class-specific steps, then T0 or HALT.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    next_state = S_T2;
            S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state == S_T2 && cls == CL_HALT)
                    next_state = S_HALT;
                else if (state == last_step(cls))
                    next_state = stop ? S_HALT : S_T0;
                else
                    next_state = step_after(state);
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

    cu_strobe_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .con_ff (con_ff),
        .strb   (strb),
        .alu_op (alu_op),
        .run    (run)
    );

    assign pc_out              = strb.pc_out;
    assign zlo_out             = strb.zlo_out;
    assign zhi_out             = strb.zhi_out;
    assign hi_out              = strb.hi_out;
    assign lo_out              = strb.lo_out;
    assign mdr_out             = strb.mdr_out;
    assign inport_out          = strb.inport_out;
    assign c_sign_extended_out = strb.c_sign_extended_out;
    assign ba_out              = strb.ba_out;
    assign pc_enable           = strb.pc_enable;
    assign pc_increment        = strb.pc_increment;
    assign mar_enable          = strb.mar_enable;
    assign mdr_enable          = strb.mdr_enable;
    assign ir_enable           = strb.ir_enable;
    assign y_enable            = strb.y_enable;
    assign z_enable            = strb.z_enable;
    assign lo_enable           = strb.lo_enable;
    assign hi_enable           = strb.hi_enable;
    assign r_in                = strb.r_in;
    assign r_out               = strb.r_out;
    assign gra                 = strb.gra;
    assign grb                 = strb.grb;
    assign grc                 = strb.grc;
    assign r15_select          = strb.r15_select;
    assign read                = strb.read;
    assign ram_write           = strb.ram_write;
    assign con_enable          = strb.con_enable;
    assign outport_enable      = strb.outport_enable;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. Expected strobes come from a table of
// strobe names per instruction step, turned into a bit mask by name lookup.
module tb_control_unit;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic        run;
    logic [4:0]  alu_op;
    logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out;
    logic c_sign_extended_out, ba_out, pc_enable, pc_increment, mar_enable;
    logic mdr_enable, ir_enable, y_enable, z_enable, lo_enable, hi_enable;
    logic r_in, r_out, gra, grb, grc, r15_select, read, ram_write, con_enable;
    logic outport_enable;
    logic [27:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
        .run(run), .alu_op(alu_op),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out),
        .lo_out(lo_out), .mdr_out(mdr_out), .inport_out(inport_out),
        .c_sign_extended_out(c_sign_extended_out), .ba_out(ba_out),
        .pc_enable(pc_enable), .pc_increment(pc_increment), .mar_enable(mar_enable),
        .mdr_enable(mdr_enable), .ir_enable(ir_enable), .y_enable(y_enable),
        .z_enable(z_enable), .lo_enable(lo_enable), .hi_enable(hi_enable),
        .r_in(r_in), .r_out(r_out), .gra(gra), .grb(grb), .grc(grc),
        .r15_select(r15_select), .read(read), .ram_write(ram_write),
        .con_enable(con_enable), .outport_enable(outport_enable)
    );

    // obs[i] is the strobe called name_of(i).
    assign obs = {outport_enable, con_enable, ram_write, read, r15_select, grc, grb, gra,
                  r_out, r_in, hi_enable, lo_enable, z_enable, y_enable, ir_enable,
                  mdr_enable, mar_enable, pc_increment, pc_enable, ba_out,
                  c_sign_extended_out, inport_out, mdr_out, lo_out, hi_out, zhi_out,
                  zlo_out, pc_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string name_of(input int j);
        case (j)
            0: return "pc_out";        1: return "zlo_out";       2: return "zhi_out";
            3: return "hi_out";        4: return "lo_out";        5: return "mdr_out";
            6: return "inport_out";    7: return "c_sign_extended_out";
            8: return "ba_out";        9: return "pc_enable";     10: return "pc_increment";
            11: return "mar_enable";   12: return "mdr_enable";   13: return "ir_enable";
            14: return "y_enable";     15: return "z_enable";     16: return "lo_enable";
            17: return "hi_enable";    18: return "r_in";         19: return "r_out";
            20: return "gra";          21: return "grb";          22: return "grc";
            23: return "r15_select";   24: return "read";         25: return "ram_write";
            26: return "con_enable";   27: return "outport_enable";
            default: return "";
        endcase
    endfunction

    // Turn a space-separated list of strobe names into a bit mask.
    function automatic logic [27:0] mask_of(input string s);
        logic [27:0] m;
        int          st;
        string       tok;
        bit          hit;
        m  = '0;
        st = 0;
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s[i] == 8'h20) begin
                if (i > st) begin
                    tok = s.substr(st, i - 1);
                    hit = 1'b0;
                    for (int j = 0; j < 28; j++)
                        if (name_of(j) == tok) begin
                            m[j] = 1'b1;
                            hit  = 1'b1;
                        end
                    if (!hit) $display("unknown strobe name in table: %s", tok);
                end
                st = i + 1;
            end
        end
        return m;
    endfunction

    // Last T-step of an instruction, by opcode value.
    function automatic int last_t(input logic [4:0] op);
        int o;
        o = int'(op);
        if (o == 0 || o == 2)   return 7;
        if (o == 1)             return 5;
        if (o >= 3 && o <= 13)  return 5;
        if (o == 14 || o == 15) return 6;
        if (o == 16 || o == 17) return 4;
        if (o == 18)            return 6;
        if (o == 19)            return 3;
        if (o == 20)            return 4;
        if (o >= 21 && o <= 24) return 3;
        return 2;
    endfunction

    // Step at which the ALU computes the instruction's own operation.
    function automatic int alu_t(input logic [4:0] op);
        int o;
        o = int'(op);
        if (o >= 3 && o <= 15)  return 4;
        if (o == 16 || o == 17) return 3;
        return -1;
    endfunction

    // Strobes asserted at step t of an instruction.
    function automatic string step_str(input logic [4:0] op, input int t, input logic cf);
        int o;
        o = int'(op);
        if (t == 0) return "pc_out mar_enable pc_increment z_enable";
        if (t == 1) return "zlo_out pc_enable read mdr_enable";
        if (t == 2) return "mdr_out ir_enable";
        if (o <= 2) begin
            if (t == 3) return "grb ba_out y_enable";
            if (t == 4) return "c_sign_extended_out z_enable";
            if (o == 1) return "zlo_out gra r_in";
            if (t == 5) return "zlo_out mar_enable";
            if (o == 0) return (t == 6) ? "read mdr_enable" : "mdr_out gra r_in";
            return (t == 6) ? "gra r_out mdr_enable" : "ram_write";
        end
        if (o >= 3 && o <= 13) begin
            if (t == 3) return "grb r_out y_enable";
            if (t == 4) return (o <= 10) ? "grc r_out z_enable" : "c_sign_extended_out z_enable";
            return "zlo_out gra r_in";
        end
        if (o == 14 || o == 15) begin
            if (t == 3) return "gra r_out y_enable";
            if (t == 4) return "grb r_out z_enable";
            if (t == 5) return "zlo_out lo_enable";
            return "zhi_out hi_enable";
        end
        if (o == 16 || o == 17) return (t == 3) ? "grb r_out z_enable" : "zlo_out gra r_in";
        if (o == 18) begin
            if (t == 3) return "gra r_out con_enable";
            if (t == 4) return "pc_out y_enable";
            if (t == 5) return "c_sign_extended_out z_enable";
            return cf ? "zlo_out pc_enable" : "zlo_out";
        end
        if (o == 19) return "gra r_out pc_enable";
        if (o == 20) return (t == 3) ? "pc_out r15_select r_in" : "gra r_out pc_enable";
        if (o == 21) return "inport_out gra r_in";
        if (o == 22) return "gra r_out outport_enable";
        if (o == 23) return "hi_out gra r_in";
        if (o == 24) return "lo_out gra r_in";
        return "";
    endfunction

    // Execute one instruction starting in T0 (sampled at negedge). stop is random on
    // non-final steps; if abort_t >= 0, clr is raised at that step and the task ends in RESET.
    task automatic run_instr(input logic [31:0] ir_val, input logic cf, input logic stop_last,
                             input int abort_t, input string tag);
        logic [4:0]  op;
        logic [27:0] exp;
        logic [4:0]  exp_alu;
        int          last;
        bit          done;
        op     = ir_val[31:27];
        last   = last_t(op);
        ir     = ir_val;
        con_ff = cf;
        done   = 1'b0;
        for (int t = 0; t <= last && !done; t++) begin
            exp     = mask_of(step_str(op, t, cf));
            exp_alu = (t == alu_t(op)) ? op : 5'b00011;
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL %s strobes op=%b T%0d got=%h want=%h", tag, op, t, obs, exp);
            end
            n_checks++;
            if (alu_op !== exp_alu) begin
                n_errors++;
                $display("FAIL %s alu_op op=%b T%0d got=%b want=%b", tag, op, t, alu_op, exp_alu);
            end
            n_checks++;
            if (run !== 1'b1) begin
                n_errors++;
                $display("FAIL %s run op=%b T%0d got=%b want=1", tag, op, t, run);
            end
            if (t == abort_t) begin
                clr  = 1'b1;
                stop = 1'b0;
                done = 1'b1;
            end else begin
                stop = (t == last) ? stop_last : 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Expect an idle state (RESET or HALT): no strobes and run low.
    task automatic test_idle(input string tag);
        n_checks++;
        if (obs !== 28'h0 || run !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle strobes=%h run=%b want strobes=0 run=0", tag, obs, run);
        end
    endtask

    task automatic test_at_t0(input string tag);
        n_checks++;
        if (obs !== mask_of(step_str(5'd0, 0, 1'b0)) || run !== 1'b1) begin
            n_errors++;
            $display("FAIL %s t0 strobes=%h run=%b want strobes=%h run=1", tag, obs, run,
                     mask_of(step_str(5'd0, 0, 1'b0)));
        end
    endtask

    // Stay in HALT for several cycles whatever stop does, then clear back to T0.
    task automatic test_halt_hold(input string tag);
        for (int k = 0; k < 3; k++) begin
            test_idle(tag);
            stop = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
        end
        test_idle(tag);
        clr  = 1'b1;
        stop = 1'b0;
        @(posedge clk);
        @(negedge clk);
        test_idle({tag, "_clr"});
        clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        test_at_t0({tag, "_exit"});
    endtask

    task automatic test_reset;
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        test_idle("reset1");
        @(posedge clk);
        @(negedge clk);
        test_idle("reset2");
        clr = 1'b0;
        @(negedge clk);
        test_at_t0("reset_release");
    endtask

    task automatic test_ldi;
        run_instr(32'h09800065, 1'b0, 1'b0, -1, "ldi");
        test_at_t0("ldi_next");
    endtask

    task automatic test_mflo;
        run_instr(32'hC1000000, 1'b1, 1'b0, -1, "mflo");
        test_at_t0("mflo_next");
    endtask

    task automatic test_br;
        run_instr(32'h9280000E, 1'b0, 1'b0, -1, "br_not_taken");
        test_at_t0("br0_next");
        run_instr(32'h9280000E, 1'b1, 1'b0, -1, "br_taken");
        test_at_t0("br1_next");
    endtask

    task automatic test_st_abort;
        run_instr(32'h10800090, 1'b0, 1'b0, 6, "st_abort");
        test_idle("st_abort_reset");
        n_checks++;
        if (ram_write !== 1'b0) begin
            n_errors++;
            $display("FAIL st_abort ram_write got=%b want=0", ram_write);
        end
        clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        test_at_t0("st_abort_t0");
    endtask

    task automatic test_mul_halt;
        run_instr(32'h71880000, 1'b0, 1'b1, -1, "mul_stop");
        test_halt_hold("mul_halt");
    endtask

    task automatic test_halt_opcode;
        run_instr({5'b11010, 27'h0}, 1'b0, 1'b0, -1, "halt_op");
        test_halt_hold("halt_op");
    endtask

    // Back-to-back random instructions, with occasional stop-at-end and clr aborts.
    task automatic test_back_to_back;
        logic [4:0]  op;
        logic [31:0] iv;
        logic        sl;
        int          ab;
        for (int n = 0; n < 200; n++) begin
            op = 5'($urandom_range(0, 31));
            iv = {op, 27'($urandom)};
            sl = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, last_t(op))) : -1;
            run_instr(iv, 1'($urandom_range(0, 1)), sl, ab, "rand");
            if (ab >= 0) begin
                test_idle("rand_abort");
                clr = 1'b0;
                @(posedge clk);
                @(negedge clk);
                test_at_t0("rand_abort_t0");
            end else if (op == 5'b11010 || sl) begin
                test_halt_hold("rand_halt");
            end
        end
    endtask

    initial begin
        clr    = 1'b1;
        ir     = 32'h0;
        con_ff = 1'b0;
        stop   = 1'b0;
        test_reset();
        test_ldi();
        test_mflo();
        test_br();
        test_st_abort();
        test_mul_halt();
        test_halt_opcode();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
